// File: rtl/io_port_pkg.sv
// io_port_pkg: FSM encodings and default sizes for the core I/O port.
// Optional feature macro: IO_TIMEOUT_EN (request timeout, see io_port_unit).
package io_port_pkg;

   typedef enum logic {
      RD_IDLE,
      RD_ACK
   } rd_state_t;

   typedef enum logic {
      WR_IDLE,
      WR_ACK
   } wr_state_t;

   localparam int DEF_DATA_W  = 16;
   localparam int DEF_N_IN    = 4;
   localparam int DEF_N_OUT   = 4;
   localparam int DEF_DEPTH   = 4;
   localparam int DEF_TIMEOUT = 255;

   // channel-select width; a single channel still gets a 1-bit index
   function automatic int chw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/io_port_if.sv
// io_port_if: external valid/ready streams plus core req/ack bus.
// master = core/environment side, slave = io_port_unit.
interface io_port_if
   import io_port_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int N_IN   = DEF_N_IN,
   parameter int N_OUT  = DEF_N_OUT
);
   localparam int RCW = chw(N_IN);
   localparam int WCW = chw(N_OUT);

   logic [N_IN*DATA_W-1:0]  in_data;
   logic [N_IN-1:0]         in_valid;
   logic [N_IN-1:0]         in_ready;
   logic [N_OUT*DATA_W-1:0] out_data;
   logic [N_OUT-1:0]        out_valid;
   logic [N_OUT-1:0]        out_ready;

   logic              rd_req;
   logic [RCW-1:0]    rd_ch;
   logic [DATA_W-1:0] rd_data;
   logic              rd_ack;
   logic              wr_req;
   logic [WCW-1:0]    wr_ch;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;
   logic              stall;
   logic              err;

   modport master (
      output in_data, in_valid, out_ready,
      output rd_req, rd_ch, wr_req, wr_ch, wr_data,
      input  in_ready, out_data, out_valid,
      input  rd_data, rd_ack, wr_ack, stall, err
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      input  rd_req, rd_ch, wr_req, wr_ch, wr_data,
      output in_ready, out_data, out_valid,
      output rd_data, rd_ack, wr_ack, stall, err
   );

endinterface

// File: rtl/io_chan_fifo.sv
// io_chan_fifo: DEPTH-entry channel FIFO, head visible combinationally.
// A full FIFO refuses a push even when popped in the same cycle.
module io_chan_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic              full,
   output logic              empty,
   output logic [DATA_W-1:0] head
);
   localparam int PW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wp;
   logic [PW-1:0]     rp;
   logic [PW:0]       cnt;
   logic              do_push;
   logic              do_pop;

   assign full    = (cnt == (PW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign head    = mem[rp];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_push) wp <= wp + PW'(1);
         if (do_pop)  rp <= rp + PW'(1);
         cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

   // storage needs no reset; count gates visibility
   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end

endmodule

// File: rtl/io_port_unit.sv
// io_port_unit: N_IN/N_OUT buffered I/O channels behind a req/ack core bus.
// `define IO_TIMEOUT_EN to force an error ack after TIMEOUT stalled cycles.
module io_port_unit
   import io_port_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int N_IN    = DEF_N_IN,
   parameter int N_OUT   = DEF_N_OUT,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input logic       clk,
   input logic       sys_rst_n,
   io_port_if.slave  bus
);
   localparam int RCW = chw(N_IN);
   localparam int WCW = chw(N_OUT);
   localparam int RN  = 2**RCW;
   localparam int WN  = 2**WCW;

   logic [N_IN-1:0]   in_full;
   logic [N_IN-1:0]   in_empty;
   logic [DATA_W-1:0] in_head [N_IN];
   logic [N_OUT-1:0]  out_full;
   logic [N_OUT-1:0]  out_empty;

   // index-space views: codes past the last channel are invalid
   logic [RN-1:0]     in_ok;
   logic [RN-1:0]     in_empty_x;
   logic [DATA_W-1:0] in_head_x [RN];
   logic [WN-1:0]     out_ok;
   logic [WN-1:0]     out_full_x;

   rd_state_t         rd_st;
   rd_state_t         rd_nx;
   logic [DATA_W-1:0] rd_q;
   logic [DATA_W-1:0] rd_d;
   logic              rd_pop;
   logic              rd_err;
   logic              rd_to;

   wr_state_t         wr_st;
   wr_state_t         wr_nx;
   logic              wr_push;
   logic              wr_err;
   logic              wr_to;

   logic              err_q;

   for (genvar i = 0; i < N_IN; i++) begin : g_in
      io_chan_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
         .clk   (clk),
         .rst_n (sys_rst_n),
         .push  (bus.in_valid[i]),
         .pop   (rd_pop & (bus.rd_ch == RCW'(i))),
         .din   (bus.in_data[i*DATA_W +: DATA_W]),
         .full  (in_full[i]),
         .empty (in_empty[i]),
         .head  (in_head[i])
      );
   end

   for (genvar j = 0; j < N_OUT; j++) begin : g_out
      io_chan_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
         .clk   (clk),
         .rst_n (sys_rst_n),
         .push  (wr_push & (bus.wr_ch == WCW'(j))),
         .pop   (bus.out_ready[j]),
         .din   (bus.wr_data),
         .full  (out_full[j]),
         .empty (out_empty[j]),
         .head  (bus.out_data[j*DATA_W +: DATA_W])
      );
   end

   for (genvar k = 0; k < RN; k++) begin : g_rx
      if (k < N_IN) begin : g_v
         assign in_ok[k]      = 1'b1;
         assign in_empty_x[k] = in_empty[k];
         assign in_head_x[k]  = in_head[k];
      end else begin : g_nv
         assign in_ok[k]      = 1'b0;
         assign in_empty_x[k] = 1'b1;
         assign in_head_x[k]  = '0;
      end
   end

   for (genvar k = 0; k < WN; k++) begin : g_wx
      if (k < N_OUT) begin : g_v
         assign out_ok[k]     = 1'b1;
         assign out_full_x[k] = out_full[k];
      end else begin : g_nv
         assign out_ok[k]     = 1'b0;
         assign out_full_x[k] = 1'b1;
      end
   end

   assign bus.in_ready  = ~in_full;
   assign bus.out_valid = ~out_empty;

`ifdef IO_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1) + 1;

   logic [TW-1:0] rd_cnt;
   logic [TW-1:0] wr_cnt;

   // a stalled cycle counts itself; the TIMEOUT-th one forces the ack
   assign rd_to = (rd_cnt == TW'(TIMEOUT - 1));
   assign wr_to = (wr_cnt == TW'(TIMEOUT - 1));

   // count cycles a request waits in idle; clear otherwise
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else begin
         if (rd_st == RD_IDLE && bus.rd_req && rd_nx == RD_IDLE)
            rd_cnt <= rd_cnt + TW'(1);
         else
            rd_cnt <= '0;
         if (wr_st == WR_IDLE && bus.wr_req && wr_nx == WR_IDLE)
            wr_cnt <= wr_cnt + TW'(1);
         else
            wr_cnt <= '0;
      end
   end
`else
   localparam int TIMEOUT_UNUSED = TIMEOUT;

   assign rd_to = 1'b0;
   assign wr_to = 1'b0;
`endif

   // read FSM next state: bad channel, data, then timeout
   always_comb begin
      rd_nx  = rd_st;
      rd_d   = rd_q;
      rd_pop = 1'b0;
      rd_err = 1'b0;
      unique case (rd_st)
         RD_IDLE: begin
            if (bus.rd_req) begin
               if (!in_ok[bus.rd_ch]) begin
                  rd_nx  = RD_ACK;
                  rd_d   = '0;
                  rd_err = 1'b1;
               end else if (!in_empty_x[bus.rd_ch]) begin
                  rd_nx  = RD_ACK;
                  rd_d   = in_head_x[bus.rd_ch];
                  rd_pop = 1'b1;
               end else if (rd_to) begin
                  rd_nx  = RD_ACK;
                  rd_d   = '0;
                  rd_err = 1'b1;
               end
            end
         end
         RD_ACK: rd_nx = RD_IDLE;
         default: rd_nx = RD_IDLE;
      endcase
   end

   // write FSM next state; a timed-out write is discarded
   always_comb begin
      wr_nx   = wr_st;
      wr_push = 1'b0;
      wr_err  = 1'b0;
      unique case (wr_st)
         WR_IDLE: begin
            if (bus.wr_req) begin
               if (!out_ok[bus.wr_ch]) begin
                  wr_nx  = WR_ACK;
                  wr_err = 1'b1;
               end else if (!out_full_x[bus.wr_ch]) begin
                  wr_nx   = WR_ACK;
                  wr_push = 1'b1;
               end else if (wr_to) begin
                  wr_nx  = WR_ACK;
                  wr_err = 1'b1;
               end
            end
         end
         WR_ACK: wr_nx = WR_IDLE;
         default: wr_nx = WR_IDLE;
      endcase
   end

   // FSM state, read result and sticky error registers
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rd_st <= RD_IDLE;
         wr_st <= WR_IDLE;
         rd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         rd_st <= rd_nx;
         wr_st <= wr_nx;
         rd_q  <= rd_d;
         err_q <= err_q | rd_err | wr_err;
      end
   end

   assign bus.rd_ack  = (rd_st == RD_ACK);
   assign bus.wr_ack  = (wr_st == WR_ACK);
   assign bus.rd_data = rd_q;
   assign bus.err     = err_q;
   assign bus.stall   = (bus.rd_req & ~bus.rd_ack)
                      | (bus.wr_req & ~bus.wr_ack);

endmodule
